// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared constants and helpers for the arbitrating multiplexer.
//   MODE_*  : encodings of the io_mode input (3 behaves like MODE_RR)
//   clog2   : index width helper, never narrower than one bit
package arb_mux_pkg;

  localparam logic [1:0] MODE_FORCED = 2'd0;
  localparam logic [1:0] MODE_FIXED  = 2'd1;
  localparam logic [1:0] MODE_RR     = 2'd2;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// rr_pick: rotating priority scan over an N-bit valid vector.
//   i_valid : request vector, bit i = channel i requesting
//   i_start : first index to examine (must be < N)
//   o_found : at least one request present
//   o_idx   : first requesting index scanning i_start, i_start+1, ..., wrapping to 0
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [SW-1:0] i_start,
  output logic          o_found,
  output logic [SW-1:0] o_idx
);

  logic          w_hi_found;
  logic [SW-1:0] w_hi_idx;
  logic          w_lo_found;
  logic [SW-1:0] w_lo_idx;

  // The rotation is split into two linear scans: indices at or above the
  // start win over the wrapped-around indices below it. This keeps every
  // vector index a loop constant.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (i_valid[i]) begin
        if (i >= int'(i_start)) begin
          if (!w_hi_found) begin
            w_hi_found = 1'b1;
            w_hi_idx   = SW'(i);
          end
        end else if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo_idx   = SW'(i);
        end
      end
    end
  end

  assign o_found = w_hi_found || w_lo_found;
  assign o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel, W-bit arbitrating multiplexer with a registered output.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   io_in_valid/bits  : N producer channels, channel i data at bits[i*W +: W]
//   io_in_ready       : one-hot (or zero) acceptance of the granted channel
//   io_mode, io_sel   : 0 forced to io_sel, 1 fixed priority, 2/3 round-robin
//   io_out_valid/bits : registered output data
//   io_out_chan       : channel index that supplied io_out_bits
//   io_out_ready      : consumer accepts the registered word
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   io_in_valid,
  input  logic [N*W-1:0] io_in_bits,
  output logic [N-1:0]   io_in_ready,
  input  logic [1:0]     io_mode,
  input  logic [SW-1:0]  io_sel,
  output logic           io_out_valid,
  output logic [W-1:0]   io_out_bits,
  output logic [SW-1:0]  io_out_chan,
  input  logic           io_out_ready
);

  logic          r_out_valid;
  logic [W-1:0]  r_out_bits;
  logic [SW-1:0] r_out_chan;
  logic [SW-1:0] r_last;

  logic          w_load_en;
  logic          w_fire;
  logic [SW-1:0] w_rr_start;
  logic          w_fix_found;
  logic [SW-1:0] w_fix_idx;
  logic          w_rr_found;
  logic [SW-1:0] w_rr_idx;
  logic          w_forced_ok;
  logic          w_grant;
  logic [SW-1:0] w_gidx;
  logic [W-1:0]  w_gdata;

  assign w_load_en  = !r_out_valid || io_out_ready;
  // Explicit wrap so a non-power-of-two N goes N-1 -> 0.
  assign w_rr_start = (r_last == SW'(N - 1)) ? '0 : r_last + 1'b1;

  rr_pick #(.N(N)) u_fixed_pick (
    .i_valid (io_in_valid),
    .i_start ('0),
    .o_found (w_fix_found),
    .o_idx   (w_fix_idx)
  );

  rr_pick #(.N(N)) u_rr_pick (
    .i_valid (io_in_valid),
    .i_start (w_rr_start),
    .o_found (w_rr_found),
    .o_idx   (w_rr_idx)
  );

  // Comparing against every legal index means io_sel >= N never matches.
  always_comb begin
    w_forced_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (io_sel == SW'(i) && io_in_valid[i]) w_forced_ok = 1'b1;
    end
  end

  always_comb begin
    w_grant = 1'b0;
    w_gidx  = '0;
    case (io_mode)
      MODE_FORCED: begin
        w_grant = w_forced_ok;
        w_gidx  = io_sel;
      end
      MODE_FIXED: begin
        w_grant = w_fix_found;
        w_gidx  = w_fix_idx;
      end
      default: begin
        w_grant = w_rr_found;
        w_gidx  = w_rr_idx;
      end
    endcase
  end

  assign w_fire = !reset && w_load_en && w_grant;

  always_comb begin
    io_in_ready = '0;
    w_gdata     = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gidx == SW'(i)) begin
        io_in_ready[i] = w_fire;
        w_gdata        = io_in_bits[i*W +: W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
      r_out_chan  <= '0;
      r_last      <= SW'(N - 1);
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_bits  <= w_gdata;
      r_out_chan  <= w_gidx;
      r_last      <= w_gidx;
    end else if (r_out_valid && io_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_out_valid = r_out_valid;
  assign io_out_bits  = r_out_bits;
  assign io_out_chan  = r_out_chan;

endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        ordy;

  logic [7:0]  valid8;
  logic [63:0] bits8;
  logic [2:0]  sel8;
  logic [7:0]  rdy8;
  logic        ov8;
  logic [7:0]  ob8;
  logic [2:0]  oc8;

  logic [4:0]  valid5;
  logic [39:0] bits5;
  logic [2:0]  sel5;
  logic [4:0]  rdy5;
  logic        ov5;
  logic [7:0]  ob5;
  logic [2:0]  oc5;

  int n_checks;
  int n_errors;

  // Model state, index 0 = N=8 instance, 1 = N=5 instance.
  logic       m_valid [2];
  logic [7:0] m_bits  [2];
  int         m_chan  [2];
  int         m_last  [2];

  arb_mux #(.N(8), .W(8)) u_dut8 (
    .clock        (clk),
    .reset        (rst),
    .io_in_valid  (valid8),
    .io_in_bits   (bits8),
    .io_in_ready  (rdy8),
    .io_mode      (mode),
    .io_sel       (sel8),
    .io_out_valid (ov8),
    .io_out_bits  (ob8),
    .io_out_chan  (oc8),
    .io_out_ready (ordy)
  );

  arb_mux #(.N(5), .W(8)) u_dut5 (
    .clock        (clk),
    .reset        (rst),
    .io_in_valid  (valid5),
    .io_in_bits   (bits5),
    .io_in_ready  (rdy5),
    .io_mode      (mode),
    .io_sel       (sel5),
    .io_out_valid (ov5),
    .io_out_bits  (ob5),
    .io_out_chan  (oc5),
    .io_out_ready (ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Grant chosen from the rules: -1 means nobody is granted.
  function automatic int pick(input int n, input logic [7:0] v, input int md,
                              input int sel, input int last);
    if (md == 0) return (sel < n && v[sel]) ? sel : -1;
    if (md == 1) begin
      for (int i = 0; i < n; i++) if (v[i]) return i;
      return -1;
    end
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (last + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input int n, input logic [7:0] v,
                            input logic [63:0] b, input int sel,
                            input logic dv, input logic [7:0] db, input int dc,
                            input logic [7:0] dr);
    int   g;
    logic load;
    logic [7:0] exp_rdy;
    chk($sformatf("dut%0d out_valid", n), int'(dv), int'(m_valid[d]));
    chk($sformatf("dut%0d out_bits", n), int'(db), int'(m_bits[d]));
    chk($sformatf("dut%0d out_chan", n), dc, m_chan[d]);
    load = !m_valid[d] || ordy;
    g = pick(n, v, int'(mode), sel, m_last[d]);
    exp_rdy = 8'h00;
    if (!rst && load && g >= 0) exp_rdy[g] = 1'b1;
    chk($sformatf("dut%0d in_ready", n), int'(dr), int'(exp_rdy));
    if (rst) begin
      m_valid[d] = 1'b0;
      m_bits[d]  = 8'h00;
      m_chan[d]  = 0;
      m_last[d]  = n - 1;
    end else if (load && g >= 0) begin
      m_valid[d] = 1'b1;
      m_bits[d]  = b[g*8 +: 8];
      m_chan[d]  = g;
      m_last[d]  = g;
    end else if (m_valid[d] && ordy) begin
      m_valid[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    model_step(0, 8, valid8, bits8, int'(sel8), ov8, ob8, int'(oc8), rdy8);
    model_step(1, 5, {3'b000, valid5}, {24'h0, bits5}, int'(sel5), ov5, ob5,
               int'(oc5), {3'b000, rdy5});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_rr5 [6];
    exp_rr5 = '{1, 3, 4, 1, 3, 4};
    n_checks = 0;
    n_errors = 0;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_bits[d]  = 8'h00;
      m_chan[d]  = 0;
    end
    m_last[0] = 7;
    m_last[1] = 4;
    rst = 1'b1; mode = 2'd2; ordy = 1'b1;
    valid8 = '0; valid5 = '0; sel8 = '0; sel5 = '0;
    for (int i = 0; i < 8; i++) bits8[i*8 +: 8] = 8'(8'h10 + i);
    for (int i = 0; i < 5; i++) bits5[i*8 +: 8] = 8'(8'h20 + i);
    tick(); tick(); tick();
    chk("reset out_valid", int'(ov8), 0);
    chk("reset out_chan", int'(oc8), 0);
    chk("reset out_bits", int'(ob8), 0);

    // Round-robin over all eight channels, full throughput.
    rst = 1'b0; valid8 = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("rr8 valid", int'(ov8), 1);
      chk("rr8 chan", int'(oc8), k % 8);
      chk("rr8 bits", int'(ob8), 8'h10 + (k % 8));
    end

    // Fixed priority sticks on channel 2, then falls to 5.
    mode = 2'd1; valid8 = 8'b1010_0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fixed chan", int'(oc8), 2);
    end
    valid8[2] = 1'b0;
    tick();
    chk("fixed next chan", int'(oc8), 5);

    // Forced select.
    mode = 2'd0; sel8 = 3'd3; valid8 = 8'b0000_1000; bits8[3*8 +: 8] = 8'hA5;
    tick();
    chk("forced bits", int'(ob8), 8'hA5);
    chk("forced chan", int'(oc8), 3);
    valid8 = 8'b1111_0111;
    tick();
    chk("forced idle ready", int'(rdy8), 0);
    chk("forced idle valid", int'(ov8), 0);

    // Backpressure then release with drain+reload in the same cycle.
    bits8[3*8 +: 8] = 8'h13; mode = 2'd2; valid8 = 8'hFF;
    tick();
    chk("bp load chan", int'(oc8), 4);
    ordy = 1'b0;
    #1;
    chk("bp ready", int'(rdy8), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp hold valid", int'(ov8), 1);
      chk("bp hold chan", int'(oc8), 4);
      chk("bp hold bits", int'(ob8), 8'h14);
      chk("bp hold ready", int'(rdy8), 0);
    end
    ordy = 1'b1;
    #1;
    chk("release ready", int'(rdy8), 8'h20);
    tick();
    chk("release valid", int'(ov8), 1);
    chk("release chan", int'(oc8), 5);
    tick();
    chk("release valid2", int'(ov8), 1);
    chk("release chan2", int'(oc8), 6);

    // Round-robin fairness on N=5 with wrap 4 -> 0.
    valid8 = '0; valid5 = 5'b11010;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr5 chan", int'(oc5), exp_rr5[k]);
      chk("rr5 bits", int'(ob5), 8'h20 + exp_rr5[k]);
    end

    // Reset while holding data.
    rst = 1'b1;
    #1;
    chk("reset ready5", int'(rdy5), 0);
    tick();
    chk("post-reset valid5", int'(ov5), 0);
    chk("post-reset chan5", int'(oc5), 0);
    chk("post-reset bits5", int'(ob5), 0);
    rst = 1'b0; valid8 = 8'b0110_0000;
    tick();
    chk("first rr5 chan", int'(oc5), 1);
    chk("first rr8 chan", int'(oc8), 5);

    // Forced select beyond N never grants.
    mode = 2'd0; sel5 = 3'd6; valid5 = 5'b11111; valid8 = '0;
    #1;
    chk("sel>=N ready", int'(rdy5), 0);
    tick();
    chk("sel>=N valid", int'(ov5), 0);
    sel5 = 3'd4;
    #1;
    chk("sel4 ready", int'(rdy5), 5'b10000);
    tick();
    chk("sel4 chan", int'(oc5), 4);
    chk("sel4 bits", int'(ob5), 8'h24);

    // Mode 3 behaves as round-robin, continuing from the forced grant.
    mode = 2'd3;
    tick();
    chk("mode3 chan", int'(oc5), 0);
    tick();
    chk("mode3 chan2", int'(oc5), 1);

    valid5 = '0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
